// File: rtl/dnn_argmax_fp16_pkg.sv
// Shared types, constants and the FP16 ordering key
// used by the argmax classifier.
package dnn_argmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
    localparam int          CLASS_IDX_W   = 4;

    // Monotonic unsigned key: NaN lowest, -0 folded onto +0,
    // negatives inverted, non-negatives get the top bit set.
    function automatic logic [15:0] fp16_order_key(input logic [15:0] x);
        logic [15:0] v;
        v = (x == FP16_NEG_ZERO) ? 16'h0000 : x;
        if (v[14:10] == FP16_EXP_MAX && v[9:0] != 10'h000)
            return 16'h0000;
        else if (v[15])
            return ~v;
        else
            return v | 16'h8000;
    endfunction

endpackage

// File: rtl/dnn_argmax_fp16_if.sv
// Logit input and classification result bundle
// between the output layer and the argmax stage.
interface dnn_argmax_fp16_if #(
    parameter int NUM_CLASSES = 10
);
    logic        in_valid;
    logic [15:0] in_data [NUM_CLASSES-1:0];
    logic        busy;
    logic        done;
    logic        class_valid;
    logic [3:0]  class_idx;
    logic [15:0] max_val;

    modport master (
        output in_valid, in_data,
        input  busy, done, class_valid, class_idx, max_val
    );

    modport slave (
        input  in_valid, in_data,
        output busy, done, class_valid, class_idx, max_val
    );
endinterface

// File: rtl/dnn_argmax_fp16_cmp.sv
// Single FP16 "candidate beats current best" comparator,
// strict so earlier indices keep ties.
module fp16_max_cmp
    import dnn_argmax_pkg::*;
(
    input  logic [15:0] cand,
    input  logic [15:0] best_key,
    output logic        gt,
    output logic [15:0] cand_key
);
    assign cand_key = fp16_order_key(cand);
    assign gt       = cand_key > best_key;
endmodule

// File: rtl/dnn_argmax_fp16.sv
// Sequential FP16 argmax over the output-layer logits:
// snapshot on completion edge, one compare per cycle.
module dnn_argmax_fp16
    import dnn_argmax_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    dnn_argmax_fp16_if.slave bus
);
    localparam logic [CLASS_IDX_W-1:0] LAST_IDX =
        CLASS_IDX_W'(NUM_CLASSES - 1);

    state_e                  state;
    logic                    in_valid_q;
    logic                    armed;
    logic [DATA_WIDTH-1:0]   snap [NUM_CLASSES-1:0];
    logic [CLASS_IDX_W-1:0]  idx;
    logic [CLASS_IDX_W-1:0]  best_idx;
    logic [15:0]             best_key;
    logic [15:0]             cand_key;
    logic                    gt;
    logic                    capture;
    logic                    finish;
    logic [CLASS_IDX_W-1:0]  fin_idx;
    logic [DATA_WIDTH-1:0]   fin_raw;
    logic [DATA_WIDTH-1:0]   fin_val;

    logic                    busy_q;
    logic                    done_q;
    logic                    class_valid_q;
    logic [CLASS_IDX_W-1:0]  class_idx_q;
    logic [DATA_WIDTH-1:0]   max_val_q;

    assign capture = (state == IDLE) && bus.in_valid
                     && !in_valid_q && armed;
    assign finish  = (state == SCAN) && (idx == LAST_IDX);
    assign fin_idx = gt ? idx : best_idx;
    assign fin_raw = snap[fin_idx];
    assign fin_val = (fin_raw == FP16_NEG_ZERO) ? '0 : fin_raw;

    fp16_max_cmp u_cmp (
        .cand     (snap[idx]),
        .best_key (best_key),
        .gt       (gt),
        .cand_key (cand_key)
    );

    // Edge detect; armed blocks a level held high across reset
    // from counting as a fresh completion edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_valid_q <= 1'b0;
            armed      <= !bus.in_valid;
        end else begin
            in_valid_q <= bus.in_valid;
            if (!bus.in_valid)
                armed <= 1'b1;
        end
    end

    // Scan FSM: snapshot, walk the index, track the running best.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            best_idx <= '0;
            best_key <= '0;
            for (int i = 0; i < NUM_CLASSES; i++)
                snap[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (capture) begin
                    snap     <= bus.in_data;
                    best_idx <= '0;
                    best_key <= fp16_order_key(bus.in_data[0]);
                    idx      <= CLASS_IDX_W'(1);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (gt) begin
                        best_idx <= idx;
                        best_key <= cand_key;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers, visible together with the done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            max_val_q     <= '0;
        end else begin
            done_q <= finish;
            if (capture)
                busy_q <= 1'b1;
            else if (finish)
                busy_q <= 1'b0;
            if (finish) begin
                class_valid_q <= 1'b1;
                class_idx_q   <= fin_idx;
                max_val_q     <= fin_val;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.class_valid = class_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.max_val     = max_val_q;

endmodule

// File: tb/tb_dnn_argmax_fp16.sv
// Self-checking bench for dnn_argmax_fp16: directed table,
// multi-cycle corner sequences and a real-valued reference model.
module tb_dnn_argmax_fp16;

    typedef logic [9:0][15:0] vec10_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] val;
    } exp_t;

    typedef struct packed {
        vec10_t d;
        exp_t   e;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_cnt;
    exp_t q[$];
    exp_t mon_e;

    dnn_argmax_fp16_if #(.NUM_CLASSES(10)) bus();

    dnn_argmax_fp16 #(.NUM_CLASSES(10), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec10_t d);
        for (int i = 0; i < 10; i++)
            bus.in_data[i] = d[i];
    endtask

    task automatic capture(input vec10_t d, input exp_t e,
                           input bit push);
        drive(d);
        bus.in_valid = 1'b1;
        if (push)
            q.push_back(e);
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 30) begin
            tick;
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=none want=done");
        end
    endtask

    function automatic vec10_t all_of(input logic [15:0] v);
        vec10_t r;
        for (int i = 0; i < 10; i++)
            r[i] = v;
        return r;
    endfunction

    function automatic bit is_nan(input logic [15:0] x);
        return x[14:10] == 5'h1F && x[9:0] != 10'h000;
    endfunction

    function automatic real to_real(input logic [15:0] x);
        real r;
        real p;
        int  e;
        int  n;
        e = int'(x[14:10]);
        p = 1.0;
        if (e == 31) begin
            r = 1.0e9;
        end else begin
            if (e == 0) begin
                r = real'(x[9:0]);
                n = -24;
            end else begin
                r = real'({1'b1, x[9:0]});
                n = e - 25;
            end
            for (int k = 0; k < 40; k++) begin
                if (k < n) p = p * 2.0;
                if (k < -n) p = p / 2.0;
            end
            r = r * p;
        end
        return x[15] ? -r : r;
    endfunction

    function automatic exp_t model(input vec10_t d);
        exp_t r;
        int   b;
        b = 0;
        for (int i = 1; i < 10; i++) begin
            if (!is_nan(d[i])
                && (is_nan(d[b]) || to_real(d[i]) > to_real(d[b])))
                b = i;
        end
        r.idx = 4'(b);
        r.val = (d[b] == 16'h8000) ? 16'h0000 : d[b];
        return r;
    endfunction

    function automatic logic [15:0] rand_fp16(input logic [15:0] p0,
                                              input logic [15:0] p1);
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0: return {s, 5'h1F, 10'($urandom_range(1, 1023))};
            1: return {s, 5'h1F, 10'h000};
            2: return {s, 15'h0000};
            3: return {s, 5'h00, 10'($urandom)};
            4: return p0;
            5: return p1;
            default:
                return {s, 5'($urandom_range(0, 30)), 10'($urandom)};
        endcase
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=done want=none");
            end else begin
                mon_e = q.pop_front();
                chk("class_idx", 32'(bus.class_idx), 32'(mon_e.idx));
                chk("max_val", 32'(bus.max_val), 32'(mon_e.val));
                chk("class_valid", 32'(bus.class_valid), 32'd1);
            end
        end
    end

    initial begin
        vec_t   tbl [6];
        vec10_t d;
        exp_t   e;
        int     cyc;
        int     dc0;
        logic [15:0] p0;
        logic [15:0] p1;

        total    = 0;
        bad      = 0;
        done_cnt = 0;

        tbl[0].d = all_of(16'h0000);
        tbl[0].d[7] = 16'h4200;
        tbl[0].e = '{idx: 4'd7, val: 16'h4200};
        tbl[1].d = all_of(16'hBC00);
        tbl[1].d[2] = 16'h3C00;
        tbl[1].d[5] = 16'h3C00;
        tbl[1].e = '{idx: 4'd2, val: 16'h3C00};
        tbl[2].d = all_of(16'hC000);
        tbl[2].d[9] = 16'hBC00;
        tbl[2].e = '{idx: 4'd9, val: 16'hBC00};
        tbl[3].d = all_of(16'hFC00);
        tbl[3].d[0] = 16'h8000;
        tbl[3].d[1] = 16'h0000;
        tbl[3].e = '{idx: 4'd0, val: 16'h0000};
        tbl[4].d = all_of(16'h0000);
        tbl[4].d[3] = 16'h7E00;
        tbl[4].d[4] = 16'h0001;
        tbl[4].e = '{idx: 4'd4, val: 16'h0001};
        tbl[5].d = all_of(16'hFE00);
        tbl[5].d[0] = 16'h7E01;
        tbl[5].e = '{idx: 4'd0, val: 16'h7E01};

        rst = 1'b0;
        bus.in_valid = 1'b0;
        drive(all_of(16'h0000));
        repeat (3) tick;
        chk("reset_outputs",
            {bus.busy, bus.done, bus.class_valid,
             bus.class_idx, bus.max_val}, 32'd0);
        rst = 1'b1;
        tick;

        capture(tbl[0].d, tbl[0].e, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("busy_k%0d", k), 32'(bus.busy),
                32'(k <= 9));
            chk($sformatf("done_k%0d", k), 32'(bus.done),
                32'(k == 10));
            tick;
        end

        for (int i = 1; i < 6; i++) begin
            capture(tbl[i].d, tbl[i].e, 1'b1);
            wait_done(cyc);
            chk($sformatf("latency_v%0d", i), 32'(cyc), 32'd10);
            repeat (2) tick;
        end

        dc0 = done_cnt;
        drive(tbl[2].d);
        q.push_back(tbl[2].e);
        bus.in_valid = 1'b1;
        tick;
        drive(tbl[0].d);
        repeat (39) tick;
        chk("held_one_done", 32'(done_cnt - dc0), 32'd1);
        bus.in_valid = 1'b0;
        repeat (2) tick;

        capture(tbl[1].d, tbl[1].e, 1'b1);
        wait_done(cyc);
        chk("b2b_first", 32'(cyc), 32'd10);
        tick;
        capture(tbl[4].d, tbl[4].e, 1'b1);
        wait_done(cyc);
        chk("b2b_second", 32'(cyc), 32'd10);
        repeat (2) tick;

        dc0 = done_cnt;
        capture(tbl[0].d, tbl[0].e, 1'b0);
        repeat (4) tick;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        tick;
        chk("midscan_reset",
            {bus.busy, bus.done, bus.class_valid,
             bus.class_idx, bus.max_val}, 32'd0);
        rst = 1'b1;
        repeat (15) begin
            tick;
            chk("no_capture_held", 32'(bus.busy), 32'd0);
        end
        chk("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);
        bus.in_valid = 1'b0;
        tick;
        capture(tbl[2].d, tbl[2].e, 1'b1);
        wait_done(cyc);
        chk("post_reset_latency", 32'(cyc), 32'd10);
        tick;

        for (int n = 0; n < 500; n++) begin
            p0 = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
            p1 = {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
            for (int i = 0; i < 10; i++)
                d[i] = rand_fp16(p0, p1);
            e = model(d);
            capture(d, e, 1'b1);
            wait_done(cyc);
            chk("rand_latency", 32'(cyc), 32'd10);
            tick;
        end

        repeat (3) tick;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
